// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM for the 8-bit multicycle MIPS datapath.
// The state register updates on the clock edge; datapath strobes and selects are a decode of that state.
// pc_en also follows zero in BRANCH, and every write/read strobe is forced low while reset_n is low.
module multicycle_control (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [3:0] state
);

  // Opcodes recognised in DECODE and MEM_ADDR
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // PC-next select encodings
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // ALU B operand select encodings
  localparam logic [1:0] B_REG    = 2'b00;
  localparam logic [1:0] B_ONE    = 2'b01;
  localparam logic [1:0] B_IMM    = 2'b10;
  localparam logic [1:0] B_BRANCH = 2'b11;

  // ALU operation encodings
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    RTYPE_EX = 4'd6,
    ALU_WB   = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    ADDI_EX  = 4'd10,
    ADDI_WB  = 4'd11
  } state_t;

  state_t state_q;

  // Raw state decode, before reset gating
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_src_d;
  logic       iord_d;
  logic       mem_read_d;
  logic       mem_write_d;
  logic       ir_write_d;
  logic       reg_dst_d;
  logic       mem_to_reg_d;
  logic       reg_write_d;
  logic       alu_src_a_d;
  logic [1:0] alu_src_b_d;
  logic [1:0] alu_op_d;

  // State register: reset overrides every transition, illegal opcodes and
  // unreachable encodings fall back to FETCH
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= FETCH;
    end else begin
      case (state_q)
        FETCH:    state_q <= DECODE;
        DECODE: begin
          case (op)
            OP_RTYPE:      state_q <= RTYPE_EX;
            OP_LW, OP_SW:  state_q <= MEM_ADDR;
            OP_BEQ:        state_q <= BRANCH;
            OP_J:          state_q <= JUMP;
            OP_ADDI:       state_q <= ADDI_EX;
            default:       state_q <= FETCH;
          endcase
        end
        MEM_ADDR: state_q <= (op == OP_LW) ? MEM_RD : MEM_WR;
        MEM_RD:   state_q <= MEM_WB;
        MEM_WB:   state_q <= FETCH;
        MEM_WR:   state_q <= FETCH;
        RTYPE_EX: state_q <= ALU_WB;
        ALU_WB:   state_q <= FETCH;
        BRANCH:   state_q <= FETCH;
        JUMP:     state_q <= FETCH;
        ADDI_EX:  state_q <= ADDI_WB;
        ADDI_WB:  state_q <= FETCH;
        default:  state_q <= FETCH;
      endcase
    end
  end

  // Moore decode of the current state into datapath controls
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src_d      = PC_ALU;
    iord_d        = 1'b0;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    ir_write_d    = 1'b0;
    reg_dst_d     = 1'b0;
    mem_to_reg_d  = 1'b0;
    reg_write_d   = 1'b0;
    alu_src_a_d   = 1'b0;
    alu_src_b_d   = B_REG;
    alu_op_d      = ALU_ADD;
    case (state_q)
      FETCH: begin
        mem_read_d  = 1'b1;
        ir_write_d  = 1'b1;
        alu_src_b_d = B_ONE;
        pc_src_d    = PC_ALU;
        pc_write    = 1'b1;
      end
      DECODE: begin
        // Branch target computed speculatively while the opcode is decoded
        alu_src_b_d = B_BRANCH;
      end
      MEM_ADDR: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = B_IMM;
      end
      MEM_RD: begin
        mem_read_d = 1'b1;
        iord_d     = 1'b1;
      end
      MEM_WB: begin
        reg_write_d  = 1'b1;
        mem_to_reg_d = 1'b1;
        reg_dst_d    = 1'b0;
      end
      MEM_WR: begin
        mem_write_d = 1'b1;
        iord_d      = 1'b1;
      end
      RTYPE_EX: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = B_REG;
        alu_op_d    = ALU_FUNCT;
      end
      ALU_WB: begin
        reg_write_d = 1'b1;
        reg_dst_d   = 1'b1;
      end
      BRANCH: begin
        alu_src_a_d   = 1'b1;
        alu_op_d      = ALU_SUB;
        pc_src_d      = PC_ALUOUT;
        pc_write_cond = 1'b1;
      end
      JUMP: begin
        pc_src_d = PC_JUMP;
        pc_write = 1'b1;
      end
      ADDI_EX: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = B_IMM;
      end
      ADDI_WB: begin
        reg_write_d = 1'b1;
        reg_dst_d   = 1'b0;
      end
      default: begin
        // Unreachable encodings: everything stays at its idle value
      end
    endcase
  end

  // Reset gating: strobes and selects are held low while reset_n is low so an
  // aborted instruction never writes; alu_src_b keeps following the state
  always_comb begin
    pc_en      = reset_n & (pc_write | (pc_write_cond & zero));
    pc_src     = reset_n ? pc_src_d : PC_ALU;
    iord       = reset_n & iord_d;
    mem_read   = reset_n & mem_read_d;
    mem_write  = reset_n & mem_write_d;
    ir_write   = reset_n & ir_write_d;
    reg_dst    = reset_n & reg_dst_d;
    mem_to_reg = reset_n & mem_to_reg_d;
    reg_write  = reset_n & reg_write_d;
    alu_src_a  = reset_n & alu_src_a_d;
    alu_src_b  = alu_src_b_d;
    alu_op     = reset_n ? alu_op_d : ALU_ADD;
    state      = state_q;
  end

endmodule
